// File: rtl/timer_regs_pkg.sv
// Register map, control/status bit positions and command encodings shared by
// the interval-timer command master and anything that talks to it.
package timer_regs_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef enum logic [2:0] {
    OP_LOAD_PERIOD = 3'd0,
    OP_START       = 3'd1,
    OP_STOP        = 3'd2,
    OP_SNAPSHOT    = 3'd3,
    OP_STATUS      = 3'd4,
    OP_CLEAR_TO    = 3'd5,
    OP_WAIT_TO     = 3'd6
  } cmd_op_e;

  // cfg is {CONT, ITO}
  function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                            input logic [1:0] cfg);
    logic [15:0] w;
    w             = '0;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    w[CTRL_CONT]  = cfg[1];
    w[CTRL_ITO]   = cfg[0];
    return w;
  endfunction

endpackage

// File: rtl/timer_cmd_master.sv
// Command-driven Avalon-MM initiator for the 16-bit interval timer: turns one-word
// commands into register access sequences and returns a single response per command.
//
// state  | meaning
// IDLE   | ready for a command
// WR_L   | write period_l
// WR_H   | write period_h
// CTRL   | write control (START or STOP form)
// SNAP_W | write snap_l to latch the counter
// RD_L   | read snap_l
// RD_H   | read snap_h, capture low half
// CAP_H  | capture high half
// RD_S   | read status
// CAP_S  | capture status / poll decision
// GAP    | idle between WAIT_TO polls
// CLR    | write status to clear TO
// RSP    | response pulse
module timer_cmd_master
  import timer_regs_pkg::*;
#(
  parameter int POLL_GAP   = 4,
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_L, S_WR_H, S_CTRL, S_SNAP_W, S_RD_L, S_RD_H,
    S_CAP_H, S_RD_S, S_CAP_S, S_GAP, S_CLR, S_RSP
  } state_e;

  localparam logic [23:0] LIMIT    = 24'(WAIT_LIMIT);
  localparam logic [15:0] GAP_LOAD = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  state_e      state_q, state_d;
  cmd_op_e     op_q, op_eff;
  logic [31:0] data_q, data_eff;
  logic [1:0]  shadow_q;
  logic [23:0] poll_q, poll_inc;
  logic [15:0] gap_q;
  logic        accept, abort_d, to_seen;
  logic        cs_d, wn_d;
  logic [2:0]  addr_d;
  logic [15:0] wd_d;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Bus words for the first cycle are built before the command is latched.
  assign op_eff    = (state_q == S_IDLE) ? cmd_op_e'(cmd_op) : op_q;
  assign data_eff  = (state_q == S_IDLE) ? cmd_data : data_q;
  assign poll_inc  = (poll_q == '1) ? poll_q : poll_q + 24'd1;
  assign to_seen   = avm_readdata[STAT_TO];

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_LOAD_PERIOD:        state_d = S_WR_L;
            OP_START, OP_STOP:     state_d = S_CTRL;
            OP_SNAPSHOT:           state_d = S_SNAP_W;
            OP_STATUS, OP_WAIT_TO: state_d = S_RD_S;
            OP_CLEAR_TO:           state_d = S_CLR;
            default:               state_d = S_RSP;
          endcase
        end
      end
      S_WR_L:   state_d = S_WR_H;
      S_WR_H:   state_d = S_RSP;
      S_CTRL:   state_d = S_RSP;
      S_SNAP_W: state_d = S_RD_L;
      S_RD_L:   state_d = S_RD_H;
      S_RD_H:   state_d = S_CAP_H;
      S_CAP_H:  state_d = S_RSP;
      S_RD_S:   state_d = S_CAP_S;
      S_CAP_S: begin
        if (op_q != OP_WAIT_TO) begin
          state_d = S_RSP;
        end else if (to_seen) begin
          state_d = S_CLR;
        end else if ((LIMIT != 24'd0) && (poll_inc >= LIMIT)) begin
          state_d = S_RSP;
          abort_d = 1'b1;
        end else if (POLL_GAP == 0) begin
          state_d = S_RD_S;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP:    if (gap_q == 16'd0) state_d = S_RD_S;
      S_CLR:    state_d = S_RSP;
      S_RSP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered, so they are decoded from the next state.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = ADDR_STATUS;
    wd_d   = '0;
    case (state_d)
      S_WR_L:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_L; wd_d = data_eff[15:0];  end
      S_WR_H:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_H; wd_d = data_eff[31:16]; end
      S_CTRL: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = ADDR_CONTROL;
        wd_d   = (op_eff == OP_START) ? ctrl_word(1'b1, 1'b0, data_eff[1:0])
                                      : ctrl_word(1'b0, 1'b1, shadow_q);
      end
      S_SNAP_W: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SNAP_L; end
      S_RD_L:   begin cs_d = 1'b1; addr_d = ADDR_SNAP_L; end
      S_RD_H:   begin cs_d = 1'b1; addr_d = ADDR_SNAP_H; end
      S_RD_S:   begin cs_d = 1'b1; addr_d = ADDR_STATUS; end
      S_CLR:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_LOAD_PERIOD;
      data_q         <= '0;
      shadow_q       <= '0;
      poll_q         <= '0;
      gap_q          <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      state_q        <= state_d;
      avm_chipselect <= cs_d;
      avm_write_n    <= wn_d;
      avm_address    <= addr_d;
      avm_writedata  <= wd_d;
      rsp_valid      <= (state_d == S_RSP);
      rsp_err        <= abort_d;
      if (accept) begin
        op_q     <= cmd_op_e'(cmd_op);
        data_q   <= cmd_data;
        rsp_data <= '0;
        if (cmd_op_e'(cmd_op) == OP_WAIT_TO) poll_q   <= '0;
        if (cmd_op_e'(cmd_op) == OP_START)   shadow_q <= cmd_data[1:0];
      end
      case (state_q)
        S_RD_H:  rsp_data[15:0]  <= avm_readdata;
        S_CAP_H: rsp_data[31:16] <= avm_readdata;
        S_CAP_S: begin
          poll_q <= poll_inc;
          if (op_q == OP_STATUS)
            rsp_data <= {30'b0, avm_readdata[STAT_RUN], avm_readdata[STAT_TO]};
          if (state_d == S_GAP) gap_q <= GAP_LOAD;
        end
        S_GAP:   gap_q <= gap_q - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmd_master.sv
// Directed bench for timer_cmd_master: two instances (unlimited and 3-poll limit)
// share a behavioural interval-timer slave through a bus mux.
module tb_timer_cmd_master;
  import timer_regs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, s_rst_n, use_b;
  logic        cmd_valid_a, cmd_valid_b;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_ready_a, rsp_valid_a, rsp_err_a, cs_a, wn_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, cs_b, wn_b;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] wd_a, wd_b;
  logic [15:0] avm_readdata;

  logic        bus_cs, bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wd;
  assign bus_cs   = use_b ? cs_b   : cs_a;
  assign bus_wn   = use_b ? wn_b   : wn_a;
  assign bus_addr = use_b ? addr_b : addr_a;
  assign bus_wd   = use_b ? wd_b   : wd_a;

  timer_cmd_master #(.POLL_GAP(4), .WAIT_LIMIT(0)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .rsp_err(rsp_err_a), .avm_address(addr_a), .avm_chipselect(cs_a), .avm_write_n(wn_a),
    .avm_writedata(wd_a), .avm_readdata(avm_readdata));

  timer_cmd_master #(.POLL_GAP(4), .WAIT_LIMIT(3)) dut_lim (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .rsp_err(rsp_err_b), .avm_address(addr_b), .avm_chipselect(cs_b), .avm_write_n(wn_b),
    .avm_writedata(wd_b), .avm_readdata(avm_readdata));

  // Behavioural interval timer slave
  logic [31:0] t_per, t_cnt, t_snap;
  logic        t_run, t_to, t_cont, t_ito;
  always @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      t_per <= '0; t_cnt <= '0; t_snap <= '0;
      t_run <= 0; t_to <= 0; t_cont <= 0; t_ito <= 0;
      avm_readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= t_per;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (bus_cs && !bus_wn) begin
        case (bus_addr)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_cont <= bus_wd[1];
            t_ito  <= bus_wd[0];
            if (bus_wd[3]) t_run <= 1'b0;
            else if (bus_wd[2]) t_run <= 1'b1;
          end
          3'd2: begin t_per[15:0]  <= bus_wd; t_cnt <= {t_per[31:16], bus_wd}; t_run <= 1'b0; end
          3'd3: begin t_per[31:16] <= bus_wd; t_cnt <= {bus_wd, t_per[15:0]};  t_run <= 1'b0; end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end
      if (bus_cs && bus_wn) begin
        case (bus_addr)
          3'd0: avm_readdata <= {14'b0, t_run, t_to};
          3'd1: avm_readdata <= {14'b0, t_cont, t_ito};
          3'd2: avm_readdata <= t_per[15:0];
          3'd3: avm_readdata <= t_per[31:16];
          3'd4: avm_readdata <= t_snap[15:0];
          3'd5: avm_readdata <= t_snap[31:16];
          default: avm_readdata <= '0;
        endcase
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
  } bus_t;
  bus_t log_q[$];
  int   cyc = 0;
  always @(posedge clk) begin
    if (bus_cs) log_q.push_back('{cyc, bus_addr, !bus_wn, bus_wd});
    cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] data, input int budget,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got;
    @(negedge clk);
    cmd_op   = op;
    cmd_data = data;
    if (use_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    got = 0; lat = 0; rd = '0; er = 1'b0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if (use_b ? rsp_valid_b : rsp_valid_a) begin
        got = 1;
        rd  = use_b ? rsp_data_b : rsp_data_a;
        er  = use_b ? rsp_err_b : rsp_err_a;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rsp_timeout: op %0d got no response, required one within %0d cycles", op, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (cmd_ready_a !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_a); end
    total++; if ({rsp_valid_a, rsp_err_a} !== 2'b00) begin bad++; $display("FAIL reset_rsp_flags: got %b want 00", {rsp_valid_a, rsp_err_a}); end
    total++; if (rsp_data_a !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_a); end
    total++; if ({cs_a, wn_a, addr_a, wd_a} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
      bad++; $display("FAIL reset_bus: got cs=%b wn=%b a=%0d wd=%h want cs=0 wn=1 a=0 wd=0", cs_a, wn_a, addr_a, wd_a);
    end
    reset_n = 1'b1;
    s_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({cmd_ready_a, cs_a, log_q.size() == 0} !== 3'b101) begin
      bad++; $display("FAIL post_reset_idle: got ready=%b cs=%b log=%0d want ready=1 cs=0 log=0", cmd_ready_a, cs_a, log_q.size());
    end
  endtask

  task automatic test_load();
    logic [31:0] rd; logic er; int lat;
    log_q.delete();
    do_cmd(OP_LOAD_PERIOD, 32'h0001_86A0, 20, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL load_latency: got %0d want 3", lat); end
    total++; if ({rd, er} !== 33'h0) begin bad++; $display("FAIL load_rsp: got data=%h err=%b want 0/0", rd, er); end
    total++; if (log_q.size() !== 2) begin bad++; $display("FAIL load_bus_count: got %0d want 2", log_q.size()); end
    if (log_q.size() >= 2) begin
      total++; if ({log_q[0].addr, log_q[0].wr, log_q[0].data} !== {3'd2, 1'b1, 16'h86A0}) begin
        bad++; $display("FAIL load_wr_l: got a%0d wr=%b d=%h want a2 wr=1 d=86a0", log_q[0].addr, log_q[0].wr, log_q[0].data);
      end
      total++; if ({log_q[1].addr, log_q[1].wr, log_q[1].data} !== {3'd3, 1'b1, 16'h0001}) begin
        bad++; $display("FAIL load_wr_h: got a%0d wr=%b d=%h want a3 wr=1 d=0001", log_q[1].addr, log_q[1].wr, log_q[1].data);
      end
      total++; if (log_q[1].cyc - log_q[0].cyc !== 1) begin
        bad++; $display("FAIL load_consecutive: got gap %0d want 1", log_q[1].cyc - log_q[0].cyc);
      end
    end
    @(negedge clk);
    total++; if ({rsp_valid_a, cmd_ready_a} !== 2'b01) begin
      bad++; $display("FAIL rsp_pulse: got valid=%b ready=%b want valid=0 ready=1", rsp_valid_a, cmd_ready_a);
    end
  endtask

  task automatic test_start_stop();
    logic [31:0] rd; logic er; int lat;
    log_q.delete();
    do_cmd(OP_START, 32'h3, 20, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL start_latency: got %0d want 2", lat); end
    total++; if (log_q.size() !== 1 || {log_q[0].addr, log_q[0].wr, log_q[0].data} !== {3'd1, 1'b1, 16'h0007}) begin
      bad++; $display("FAIL start_ctrl: got n=%0d a%0d d=%h want n=1 a1 d=0007", log_q.size(), log_q[0].addr, log_q[0].data);
    end
    do_cmd(OP_STATUS, 32'h0, 20, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL status_latency: got %0d want 3", lat); end
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL status_running: got %h want 2", rd); end
    log_q.delete();
    do_cmd(OP_STOP, 32'h0, 20, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL stop_latency: got %0d want 2", lat); end
    total++; if (log_q.size() !== 1 || {log_q[0].addr, log_q[0].wr, log_q[0].data} !== {3'd1, 1'b1, 16'h000B}) begin
      bad++; $display("FAIL stop_ctrl: got n=%0d a%0d d=%h want n=1 a1 d=000b", log_q.size(), log_q[0].addr, log_q[0].data);
    end
    do_cmd(OP_STATUS, 32'h0, 20, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL status_stopped: got %h want 0", rd); end
  endtask

  task automatic test_snapshot();
    logic [31:0] rd; logic er; int lat;
    do_cmd(OP_LOAD_PERIOD, 32'd100, 20, rd, er, lat);
    do_cmd(OP_START, 32'h2, 20, rd, er, lat);
    repeat (7) @(negedge clk);
    log_q.delete();
    do_cmd(OP_SNAPSHOT, 32'h0, 20, rd, er, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL snap_latency: got %0d want 5", lat); end
    total++; if (log_q.size() !== 3) begin bad++; $display("FAIL snap_bus_count: got %0d want 3", log_q.size()); end
    if (log_q.size() >= 3) begin
      total++; if ({log_q[0].addr, log_q[0].wr, log_q[0].data, log_q[1].addr, log_q[1].wr, log_q[2].addr, log_q[2].wr}
                   !== {3'd4, 1'b1, 16'h0, 3'd4, 1'b0, 3'd5, 1'b0}) begin
        bad++; $display("FAIL snap_seq: got a%0d/%b a%0d/%b a%0d/%b want a4/1 a4/0 a5/0",
                        log_q[0].addr, log_q[0].wr, log_q[1].addr, log_q[1].wr, log_q[2].addr, log_q[2].wr);
      end
      total++; if (log_q[2].cyc - log_q[0].cyc !== 2) begin
        bad++; $display("FAIL snap_consecutive: got span %0d want 2", log_q[2].cyc - log_q[0].cyc);
      end
    end
    total++; if (rd > 32'd100 || rd !== t_snap) begin
      bad++; $display("FAIL snap_value: got %h want %h within 0..100", rd, t_snap);
    end
    do_cmd(OP_STOP, 32'h0, 20, rd, er, lat);
    do_cmd(OP_LOAD_PERIOD, 32'h0002_0010, 20, rd, er, lat);
    do_cmd(OP_SNAPSHOT, 32'h0, 20, rd, er, lat);
    total++; if (rd !== 32'h0002_0010) begin bad++; $display("FAIL snap_32bit: got %h want 00020010", rd); end
    log_q.delete();
    do_cmd(OP_CLEAR_TO, 32'h0, 20, rd, er, lat);
    total++; if (lat !== 2 || log_q.size() !== 1 || {log_q[0].addr, log_q[0].wr, log_q[0].data} !== {3'd0, 1'b1, 16'h0}) begin
      bad++; $display("FAIL clear_to: got lat=%0d n=%0d want lat=2 n=1 a0 wr 0", lat, log_q.size());
    end
  endtask

  task automatic test_wait_to();
    logic [31:0] rd; logic er; int lat; int nr, nw, other;
    do_cmd(OP_LOAD_PERIOD, 32'd20, 20, rd, er, lat);
    do_cmd(OP_START, 32'h0, 20, rd, er, lat);
    log_q.delete();
    do_cmd(OP_WAIT_TO, 32'h0, 2000, rd, er, lat);
    nr = 0; nw = 0; other = 0;
    foreach (log_q[i]) begin
      if (log_q[i].addr != 3'd0) other++;
      else if (log_q[i].wr) nw++;
      else nr++;
    end
    total++; if ({rd, er} !== 33'h0) begin bad++; $display("FAIL wait_rsp: got data=%h err=%b want 0/0", rd, er); end
    total++; if (other !== 0 || nw !== 1 || nr < 2) begin
      bad++; $display("FAIL wait_bus: got reads=%0d writes=%0d other=%0d want reads>=2 writes=1 other=0", nr, nw, other);
    end
    if (log_q.size() >= 2) begin
      total++; if (log_q[log_q.size()-1].wr !== 1'b1) begin bad++; $display("FAIL wait_last_clr: got wr=0 want wr=1"); end
      total++; if (log_q[1].cyc - log_q[0].cyc !== 6) begin
        bad++; $display("FAIL wait_poll_gap: got %0d want 6", log_q[1].cyc - log_q[0].cyc);
      end
    end
    do_cmd(OP_STATUS, 32'h0, 20, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wait_status_after: got %h want 0", rd); end
  endtask

  task automatic test_wait_limit();
    logic [31:0] rd; logic er; int lat; int nr, nw;
    @(negedge clk);
    use_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      log_q.delete();
      do_cmd(OP_WAIT_TO, 32'h0, 200, rd, er, lat);
      nr = 0; nw = 0;
      foreach (log_q[i]) begin
        if (log_q[i].wr) nw++;
        else if (log_q[i].addr == 3'd0) nr++;
      end
      total++; if ({rd, er} !== {32'h0, 1'b1}) begin bad++; $display("FAIL limit_rsp%0d: got data=%h err=%b want 0/1", k, rd, er); end
      total++; if (nr !== 3 || nw !== 0 || log_q.size() !== 3) begin
        bad++; $display("FAIL limit_bus%0d: got reads=%0d writes=%0d n=%0d want 3/0/3", k, nr, nw, log_q.size());
      end
    end
    @(negedge clk);
    use_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    int viol;
    log_q.delete();
    @(negedge clk);
    cmd_op = OP_SNAPSHOT; cmd_data = '0; cmd_valid_a = 1'b1;
    @(posedge clk);
    #1 cmd_valid_a = 1'b0;
    @(negedge clk);
    total++; if ({cs_a, wn_a, addr_a} !== {1'b1, 1'b0, 3'd4}) begin
      bad++; $display("FAIL midrst_snap_w: got cs=%b wn=%b a%0d want cs=1 wn=0 a4", cs_a, wn_a, addr_a);
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++; if ({cs_a, wn_a, rsp_valid_a} !== 3'b010) begin
      bad++; $display("FAIL midrst_bus_idle: got cs=%b wn=%b rv=%b want 0 1 0", cs_a, wn_a, rsp_valid_a);
    end
    viol = 0;
    repeat (2) begin @(negedge clk); if (cs_a || rsp_valid_a) viol++; end
    reset_n = 1'b1;
    repeat (12) begin @(negedge clk); if (cs_a || rsp_valid_a) viol++; end
    total++; if (viol !== 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", viol); end
    total++; if (cmd_ready_a !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", cmd_ready_a); end
    total++; if (log_q.size() !== 1) begin bad++; $display("FAIL midrst_bus_count: got %0d want 1", log_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0; s_rst_n = 1'b0; use_b = 1'b0;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_op = '0; cmd_data = '0;
    test_reset();
    test_load();
    test_start_stop();
    test_snapshot();
    test_wait_to();
    test_wait_limit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
